// File: rtl/approx_adder_evaluator.sv
// Exhaustive evaluator for an approximate adder: sweeps every (a,b) pair, accumulates error-distance stats.
// Optional macro APPROX_EVAL_MEP_EN adds the total_sq_ed accumulator (sum of ED squared).
module approx_adder_evaluator #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic [WIDTH:0]       approx_sum_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH:0]     total_cases,
   output logic [2*WIDTH:0]     error_cases,
   output logic [3*WIDTH:0]     total_ed,
   output logic [WIDTH:0]       max_ed
`ifdef APPROX_EVAL_MEP_EN
   ,
   output logic [4*WIDTH+1:0]   total_sq_ed
`endif
);

   // state  | meaning
   // IDLE   | after reset, results zero, waiting for start
   // DRIVE  | operands held for SETTLE cycles
   // SAMPLE | ED of current pair computed and accumulated on exit
   // DONE   | sweep complete, results held until next start
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   settle_cnt;
   logic            launch;
   logic            accum;
   logic            last_pair;
   logic [WIDTH:0]  exact;
   logic [WIDTH:0]  ed;

   assign last_pair = (&a_out) & (&b_out);
   assign exact     = {1'b0, a_out} + {1'b0, b_out};
   assign ed        = (exact >= approx_sum_in) ? (exact - approx_sum_in) : (approx_sum_in - exact);

`ifdef APPROX_EVAL_MEP_EN
   logic [2*WIDTH+1:0] ed_ext;
   logic [2*WIDTH+1:0] ed_sq;
   assign ed_ext = (2*WIDTH+2)'(ed);
   assign ed_sq  = ed_ext * ed_ext;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      accum   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               launch  = 1'b1;
            end
         end
         DRIVE: begin
            busy = 1'b1;
            if (settle_cnt == '0) state_d = SAMPLE;
         end
         SAMPLE: begin
            busy    = 1'b1;
            accum   = 1'b1;
            state_d = last_pair ? DONE : DRIVE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_d = DRIVE;
               launch  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt  <= '0;
         a_out       <= '0;
         b_out       <= '0;
         total_cases <= '0;
         error_cases <= '0;
         total_ed    <= '0;
         max_ed      <= '0;
`ifdef APPROX_EVAL_MEP_EN
         total_sq_ed <= '0;
`endif
      end else if (launch) begin
         settle_cnt  <= SETTLE_LOAD;
         a_out       <= '0;
         b_out       <= '0;
         total_cases <= '0;
         error_cases <= '0;
         total_ed    <= '0;
         max_ed      <= '0;
`ifdef APPROX_EVAL_MEP_EN
         total_sq_ed <= '0;
`endif
      end else if (state_q == DRIVE && settle_cnt != '0) begin
         settle_cnt <= settle_cnt - CW'(1);
      end else if (accum) begin
         total_cases <= total_cases + (2*WIDTH+1)'(1);
         error_cases <= error_cases + (2*WIDTH+1)'(ed != '0);
         total_ed    <= total_ed + (3*WIDTH+1)'(ed);
         if (ed > max_ed) max_ed <= ed;
`ifdef APPROX_EVAL_MEP_EN
         total_sq_ed <= total_sq_ed + (4*WIDTH+2)'(ed_sq);
`endif
         // Operands stay on the last pair once the sweep finishes
         if (!last_pair) begin
            {a_out, b_out} <= {a_out, b_out} + (2*WIDTH)'(1);
            settle_cnt     <= SETTLE_LOAD;
         end
      end
   end

endmodule

// File: tb/tb_approx_adder_evaluator.sv
// Bench: WIDTH=2/SETTLE=1 evaluator checked every cycle against a pair-count model; WIDTH=5/SETTLE=3 checked at sweep end.
module tb_approx_adder_evaluator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start2;
   logic [1:0]  a2, b2;
   logic [2:0]  approx2;
   logic        busy2, done2;
   logic [4:0]  tc2, ec2;
   logic [6:0]  ted2;
   logic [2:0]  med2;

   logic        start5;
   logic [4:0]  a5, b5;
   logic [5:0]  approx5;
   logic        busy5, done5;
   logic [10:0] tc5, ec5;
   logic [15:0] ted5;
   logic [5:0]  med5;

`ifdef APPROX_EVAL_MEP_EN
   logic [9:0]  sq2;
   logic [21:0] sq5;
`endif

   logic [2:0] tab2 [16];
   logic [5:0] tab5 [1024];

   assign approx2 = tab2[{a2, b2}];
   assign approx5 = tab5[{a5, b5}];

   approx_adder_evaluator #(.WIDTH(2), .SETTLE(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
      .approx_sum_in(approx2), .busy(busy2), .done(done2), .total_cases(tc2),
      .error_cases(ec2), .total_ed(ted2), .max_ed(med2)
`ifdef APPROX_EVAL_MEP_EN
      , .total_sq_ed(sq2)
`endif
   );

   approx_adder_evaluator #(.WIDTH(5), .SETTLE(3)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .a_out(a5), .b_out(b5),
      .approx_sum_in(approx5), .busy(busy5), .done(done5), .total_cases(tc5),
      .error_cases(ec5), .total_ed(ted5), .max_ed(med5)
`ifdef APPROX_EVAL_MEP_EN
      , .total_sq_ed(sq5)
`endif
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   // Model of dut2: cycles since accepted start, plus prefix sums over the sweep order
   bit     m_run = 0, m_done = 0;
   int     m_k = 0;
   longint p_err [17];
   longint p_ed  [17];
   longint p_max [17];
   longint p_sq  [17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_tab2(input int mode);
      for (int i = 0; i < 16; i++) begin
         int s;
         s = i / 4 + i % 4;
         case (mode)
            0:       tab2[i] = 3'(s);
            1:       tab2[i] = 3'(s & ~1);
            2:       tab2[i] = 3'd0;
            default: tab2[i] = 3'($urandom_range(0, 7));
         endcase
      end
   endtask

   task automatic run_sweep2(input int pulse_at, output int n);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      n = 0;
      chk("start_busy", 64'(busy2), 64'd1);
      chk("start_done_cleared", 64'(done2), 64'd0);
      chk("start_total_cleared", 64'(tc2), 64'd0);
      while (!done2 && n < 200) begin
         @(negedge clk);
         n++;
         start2 = (n == pulse_at);
      end
      start2 = 1'b0;
      if (!done2) chk("sweep2_timeout", 64'(done2), 64'd1);
   endtask

   initial begin
      int n;
      longint e_err, e_ed, e_max, e_sq;
      rst_n = 1'b0; start2 = 1'b0; start5 = 1'b0;
      for (int i = 0; i < 17; i++) begin p_err[i] = 0; p_ed[i] = 0; p_max[i] = 0; p_sq[i] = 0; end
      set_tab2(0);
      for (int i = 0; i < 1024; i++) tab5[i] = '0;

      fork
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               m_run = 0; m_done = 0; m_k = 0;
            end else if (start2 && !m_run) begin
               m_run = 1; m_done = 0; m_k = 0;
               for (int i = 0; i < 16; i++) begin
                  int ex, ed;
                  ex = i / 4 + i % 4;
                  ed = (ex > int'(tab2[i])) ? ex - int'(tab2[i]) : int'(tab2[i]) - ex;
                  p_err[i+1] = p_err[i] + ((ed != 0) ? 1 : 0);
                  p_ed[i+1]  = p_ed[i] + ed;
                  p_max[i+1] = (ed > p_max[i]) ? ed : p_max[i];
                  p_sq[i+1]  = p_sq[i] + ed * ed;
               end
            end else if (m_run) begin
               m_k++;
               if (m_k == 32) begin m_run = 0; m_done = 1; end
            end
         end
         forever begin
            @(negedge clk);
            if (chk_en) begin
               int comp, pair;
               comp = m_k / 2;
               pair = (comp < 16) ? comp : 15;
               chk("cyc_busy", 64'(busy2), 64'(m_run));
               chk("cyc_done", 64'(done2), 64'(m_done));
               chk("cyc_a", 64'(a2), 64'(pair / 4));
               chk("cyc_b", 64'(b2), 64'(pair % 4));
               chk("cyc_total_cases", 64'(tc2), 64'(comp));
               chk("cyc_error_cases", 64'(ec2), 64'(p_err[comp]));
               chk("cyc_total_ed", 64'(ted2), 64'(p_ed[comp]));
               chk("cyc_max_ed", 64'(med2), 64'(p_max[comp]));
`ifdef APPROX_EVAL_MEP_EN
               chk("cyc_total_sq_ed", 64'(sq2), 64'(p_sq[comp]));
`endif
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy2), 64'd0);
      chk("reset_a_out", 64'(a2), 64'd0);
      rst_n = 1'b1;
      chk_en = 1;
      @(negedge clk);
      chk("idle_done", 64'(done2), 64'd0);
      chk("idle_total_cases", 64'(tc2), 64'd0);

      set_tab2(0);
      run_sweep2(-1, n);
      chk("exact_done_latency", 64'(n), 64'd32);
      chk("exact_total_cases", 64'(tc2), 64'd16);
      chk("exact_error_cases", 64'(ec2), 64'd0);
      chk("exact_total_ed", 64'(ted2), 64'd0);
      chk("exact_max_ed", 64'(med2), 64'd0);

      repeat (3) @(negedge clk);
      chk("done_held", 64'(done2), 64'd1);

      set_tab2(1);
      run_sweep2(-1, n);
      chk("lsb0_total_cases", 64'(tc2), 64'd16);
      chk("lsb0_error_cases", 64'(ec2), 64'd8);
      chk("lsb0_total_ed", 64'(ted2), 64'd8);
      chk("lsb0_max_ed", 64'(med2), 64'd1);
`ifdef APPROX_EVAL_MEP_EN
      chk("lsb0_total_sq_ed", 64'(sq2), 64'd8);
`endif

      set_tab2(2);
      run_sweep2(-1, n);
      chk("zero_error_cases", 64'(ec2), 64'd15);
      chk("zero_total_ed", 64'(ted2), 64'd48);
      chk("zero_max_ed", 64'(med2), 64'd6);
`ifdef APPROX_EVAL_MEP_EN
      chk("zero_total_sq_ed", 64'(sq2), 64'd184);
`endif

      set_tab2(0);
      run_sweep2(7, n);
      chk("midstart_latency", 64'(n), 64'd32);
      chk("midstart_total_cases", 64'(tc2), 64'd16);
      run_sweep2(20, n);
      chk("midstart2_latency", 64'(n), 64'd32);

      for (int r = 0; r < 4; r++) begin
         set_tab2(3);
         run_sweep2(-1, n);
         chk("rand_latency", 64'(n), 64'd32);
      end

      // Reset while DRIVE holds pair (1,2)
      set_tab2(2);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      n = 0;
      while (!(m_run && m_k == 12) && n < 100) begin @(negedge clk); n++; end
      chk("pre_reset_a", 64'(a2), 64'd1);
      chk("pre_reset_b", 64'(b2), 64'd2);
      chk("pre_reset_total_cases", 64'(tc2), 64'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_busy", 64'(busy2), 64'd0);
      chk("async_reset_done", 64'(done2), 64'd0);
      chk("async_reset_a", 64'(a2), 64'd0);
      chk("async_reset_b", 64'(b2), 64'd0);
      chk("async_reset_total_cases", 64'(tc2), 64'd0);
      chk("async_reset_total_ed", 64'(ted2), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_resume_busy", 64'(busy2), 64'd0);
      set_tab2(0);
      run_sweep2(-1, n);
      chk("post_reset_latency", 64'(n), 64'd32);
      chk("post_reset_total_cases", 64'(tc2), 64'd16);
      chk("post_reset_error_cases", 64'(ec2), 64'd0);

      // Wide instance with a random adder table
      e_err = 0; e_ed = 0; e_max = 0; e_sq = 0;
      for (int a = 0; a < 32; a++)
         for (int b = 0; b < 32; b++) begin
            int v, ed;
            v = (a + b + int'($urandom_range(0, 2)) - 1);
            if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 63));
            if (v < 0) v = 0;
            if (v > 63) v = 63;
            tab5[a * 32 + b] = 6'(v);
            ed = (a + b > v) ? a + b - v : v - (a + b);
            if (ed != 0) e_err++;
            e_ed += ed;
            if (ed > e_max) e_max = ed;
            e_sq += ed * ed;
         end
      @(negedge clk); start5 = 1'b1;
      @(negedge clk); start5 = 1'b0;
      n = 0;
      while (!done5 && n < 6000) begin @(negedge clk); n++; end
      if (!done5) chk("sweep5_timeout", 64'(done5), 64'd1);
      chk("w5_done_latency", 64'(n), 64'd4096);
      chk("w5_total_cases", 64'(tc5), 64'd1024);
      chk("w5_error_cases", 64'(ec5), 64'(e_err));
      chk("w5_total_ed", 64'(ted5), 64'(e_ed));
      chk("w5_max_ed", 64'(med5), 64'(e_max));
      chk("w5_busy", 64'(busy5), 64'd0);
      chk("w5_last_a", 64'(a5), 64'd31);
      chk("w5_last_b", 64'(b5), 64'd31);
`ifdef APPROX_EVAL_MEP_EN
      chk("w5_total_sq_ed", 64'(sq5), 64'(e_sq));
`else
      if (e_sq < 0) chk("w5_sq_sign", 64'(e_sq), 64'd0);
`endif

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
